// File: rtl/pipeline_types.sv
// Shared pipeline types: request edge pairs and the signal_driver FSM state set.
package pipeline_types;

    typedef struct packed {
        logic rising;
        logic falling;
    } edges_t;

    // Bit 1 of the encoding is the output level, bit 0 marks a hold window.
    typedef enum logic [1:0] {
        LOW_STABLE  = 2'b00,
        LOW_HOLD    = 2'b01,
        HIGH_STABLE = 2'b10,
        HIGH_HOLD   = 2'b11
    } driver_state_t;

    localparam driver_state_t DRIVER_STATE_RESET = LOW_STABLE;

    function automatic driver_state_t driver_reset_state(input logic level);
        return level ? HIGH_STABLE : DRIVER_STATE_RESET;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Minimum-hold countdown: loads MIN_HOLD_CYCLES-1, decrements to zero and then stays there.
module hold_timer #(
    parameter int MIN_HOLD_CYCLES = 5
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_load,
    output logic o_zero
);

    localparam int CW = $clog2(MIN_HOLD_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MIN_HOLD_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign o_zero = (count == '0);

endmodule

// File: rtl/signal_driver.sv
// Glitch-free level driver with a minimum hold per level and illegal-request reporting.
// Optional feature macro: SIGNAL_DRIVER_PENDING_EN (one-deep pending request during holds).
module signal_driver
    import pipeline_types::*;
#(
    parameter int   MIN_HOLD_CYCLES = 5,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic   i_clk,
    input  logic   i_reset_n,
    input  edges_t i_edges,
    output logic   o_signal,
    output logic   o_busy,
    output logic   o_dropped
);

    driver_state_t state;
    driver_state_t state_next;
    logic          sig_next;
    logic          drop_next;
    logic          load;
    logic          timer_zero;
    logic          conflict;
    logic          opposite;
    logic          same;

`ifdef SIGNAL_DRIVER_PENDING_EN
    logic pending;
    logic pending_next;
`endif

    assign conflict = i_edges.rising & i_edges.falling;
    assign opposite = o_signal ? (i_edges.falling & ~i_edges.rising)
                               : (i_edges.rising & ~i_edges.falling);
    assign same     = o_signal ? (i_edges.rising & ~i_edges.falling)
                               : (i_edges.falling & ~i_edges.rising);

    always_comb begin
        state_next = state;
        sig_next   = o_signal;
        drop_next  = conflict;
        load       = 1'b0;
`ifdef SIGNAL_DRIVER_PENDING_EN
        pending_next = pending;
`endif
        case (state)
            LOW_STABLE, HIGH_STABLE: begin
                if (opposite) begin
                    state_next = o_signal ? LOW_HOLD : HIGH_HOLD;
                    sig_next   = ~o_signal;
                    load       = 1'b1;
                end
            end
            LOW_HOLD, HIGH_HOLD: begin
`ifdef SIGNAL_DRIVER_PENDING_EN
                // A request arriving on the expiry cycle is merged before the decision.
                if (opposite) begin
                    pending_next = 1'b1;
                end else if (same) begin
                    pending_next = 1'b0;
                end
                if (timer_zero) begin
                    if (pending_next) begin
                        state_next = (state == LOW_HOLD) ? HIGH_HOLD : LOW_HOLD;
                        sig_next   = ~o_signal;
                        load       = 1'b1;
                    end else begin
                        state_next = (state == LOW_HOLD) ? LOW_STABLE : HIGH_STABLE;
                    end
                    pending_next = 1'b0;
                end
`else
                drop_next = conflict | opposite;
                if (timer_zero) begin
                    state_next = (state == LOW_HOLD) ? LOW_STABLE : HIGH_STABLE;
                end
`endif
            end
            default: begin
                state_next = driver_reset_state(RESET_LEVEL);
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= driver_reset_state(RESET_LEVEL);
            o_signal  <= RESET_LEVEL;
            o_dropped <= 1'b0;
        end else begin
            state     <= state_next;
            o_signal  <= sig_next;
            o_dropped <= drop_next;
        end
    end

`ifdef SIGNAL_DRIVER_PENDING_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending <= 1'b0;
        end else begin
            pending <= pending_next;
        end
    end
`endif

    assign o_busy = (state == LOW_HOLD) || (state == HIGH_HOLD);

    hold_timer #(
        .MIN_HOLD_CYCLES(MIN_HOLD_CYCLES)
    ) u_hold_timer (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_load   (load),
        .o_zero   (timer_zero)
    );

endmodule

// File: doc/signal_driver.md
SIGNAL_DRIVER -- requirements
Module: signal_driver

Interface
REQ-001 Parameter MIN_HOLD_CYCLES, default 5: minimum cycles o_signal SHALL hold each level after a transition; legal range >= 2.
REQ-002 Parameter RESET_LEVEL, default 1'b0: level of o_signal during and after reset.
REQ-003 i_clk  input  1: single clock for the whole block.
REQ-004 i_reset_n  input  1: reset, asynchronous and active-low.
REQ-005 i_edges  input  edges_t: single-cycle requests; .rising drives the output high and .falling drives it low.
REQ-006 o_signal  output  1: registered, glitch-free output level.
REQ-007 o_busy  output  1: high while the minimum-hold window is running.
REQ-008 o_dropped  output  1: one-cycle pulse when a request is discarded.

Function
REQ-009 The FSM SHALL have four states: LOW_STABLE, LOW_HOLD, HIGH_STABLE, HIGH_HOLD.
REQ-010 A rising request in LOW_STABLE SHALL drive o_signal to 1 on the next clock edge and enter HIGH_HOLD; falling in HIGH_STABLE mirrors this (1-cycle latency).
REQ-011 On entering a HOLD state, the hold counter SHALL load MIN_HOLD_CYCLES-1 and decrement each cycle.
REQ-012 When the counter is 0 in a HOLD state, the FSM SHALL move to the matching STABLE state, so each level lasts >= MIN_HOLD_CYCLES cycles.
REQ-013 The counter width SHALL be $clog2(MIN_HOLD_CYCLES); the counter SHALL never wrap below 0.
REQ-014 o_busy SHALL equal 1 exactly in LOW_HOLD and HIGH_HOLD.
REQ-015 A request equal to the current o_signal level SHALL be a no-op: no state change and no o_dropped.
REQ-016 A cycle with rising and falling both set SHALL be discarded as illegal and pulse o_dropped, whatever the state.
REQ-017 A request opposite to the current level arriving in a HOLD state SHALL be handled per REQ-022/REQ-023.
REQ-018 o_dropped SHALL be registered and asserted for exactly one cycle per discarded request.

Reset
REQ-019 Reset SHALL set: o_signal=RESET_LEVEL, o_busy=0, o_dropped=0, counter=0, pending cleared, state=LOW_STABLE or HIGH_STABLE matching RESET_LEVEL.
REQ-020 Reset asserted mid-hold SHALL abort the hold immediately; no pending request survives reset.
REQ-021 After reset release, the first request SHALL be accepted with no hold window.

Configuration
REQ-022 With SIGNAL_DRIVER_PENDING_EN defined:
- a one-deep pending register latches opposite-level requests during HOLD; a later opposite request overwrites it.
- a same-level request during HOLD clears pending.
- on the cycle the counter reaches 0 with pending set, the FSM transitions directly to the opposite HOLD state, toggles o_signal, and clears pending.
- an overwrite SHALL NOT pulse o_dropped.
REQ-023 Without SIGNAL_DRIVER_PENDING_EN: no pending register is built; opposite-level requests during HOLD are discarded and pulse o_dropped.

Structure
REQ-024 edges_t and a new driver_state_t enum (the four states) SHALL reside in pipeline_types; a reset constant for the FSM state SHALL be added there.
REQ-025 The load/decrement/zero counter SHALL be a sub-module named hold_timer, with ports i_clk, i_reset_n, i_load, o_zero, and parameter MIN_HOLD_CYCLES.

Verification
REQ-026 Test with MIN_HOLD_CYCLES=5 and RESET_LEVEL=0:
- Stimulus: release reset; rising pulse at cycle 10.
- Response: o_signal=1 from cycle 11; o_busy=1 for cycles 11-15; o_busy=0 at cycle 16.
REQ-027 Test with the same parameters:
- Stimulus: rising at cycle 10, falling at cycle 12.
- Response with the macro: o_signal falls at cycle 16, high exactly 5 cycles.
- Response without the macro: o_dropped=1 at cycle 13 and o_signal stays 1.
REQ-028 Test the same-cycle conflict:
- Stimulus: rising and falling together at cycle 10.
- Response: o_signal unchanged, o_dropped=1 at cycle 11, o_busy=0.
REQ-029 Test reset during a hold:
- Stimulus: rising at cycle 10; reset asserted at cycle 13.
- Response: o_signal=0 and o_busy=0 immediately, and the pending register is empty.
REQ-030 Loopback test:
- Setup: o_signal drives a synchronizer with DEBOUNCE_CYCLES=5.
- Stimulus: random request stream of 1000 cycles.
- Response: every o_signal transition yields exactly one synchronizer edge pulse, and no level shorter than 5 cycles appears.
